// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// Pipeline memory-access stage: word load/store over a ready/valid data port,
// writeback selection, stall generation and access timeout.
module mem_stage #(
  parameter int         TIMEOUT = 16,
  parameter logic [1:0] RES_ALU = 2'b00,
  parameter logic [1:0] RES_MEM = 2'b01,
  parameter logic [1:0] RES_PC  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        rd_write_enable,
  input  logic [4:0]  rd_write_addr,
  input  logic [1:0]  res_src,
  input  logic        mem_write_enable,
  input  logic [31:0] exec_out,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] next_pc,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_rd_we,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   addr_reg, wdata_reg;
  logic          we_reg, rd_we_reg;
  logic [4:0]    rd_addr_reg;

  logic          wb_valid_reg, wb_valid_next;
  logic          wb_rd_we_reg, wb_rd_we_next;
  logic [4:0]    wb_rd_addr_reg, wb_rd_addr_next;
  logic [31:0]   wb_data_reg, wb_data_next;
  logic          misalign_reg, misalign_next;
  logic          bus_err_reg, bus_err_next;

  logic memop, aligned, idle, issue, timeout_hit, done, abort;

  assign memop       = in_valid & (mem_write_enable | (res_src == RES_MEM));
  assign aligned     = (exec_out[1:0] == 2'b00);
  assign idle        = (state_reg == IDLE);
  assign issue       = idle & memop & aligned;
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
  // A store completes on ready; a load completes only when its data arrives.
  assign done  = ((state_reg == REQ) & dmem_ready & (we_reg | dmem_rvalid))
               | ((state_reg == RESP) & dmem_rvalid);
  assign abort = ~idle & ~done & timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      we_reg         <= 1'b0;
      rd_we_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      wb_valid_reg   <= 1'b0;
      wb_rd_we_reg   <= 1'b0;
      wb_rd_addr_reg <= '0;
      wb_data_reg    <= '0;
      misalign_reg   <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        cnt_reg     <= '0;
        addr_reg    <= exec_out;
        wdata_reg   <= mem_write_data;
        we_reg      <= mem_write_enable;
        rd_we_reg   <= rd_write_enable;
        rd_addr_reg <= rd_write_addr;
      end else if (!idle) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      wb_valid_reg   <= wb_valid_next;
      wb_rd_we_reg   <= wb_rd_we_next;
      wb_rd_addr_reg <= wb_rd_addr_next;
      wb_data_reg    <= wb_data_next;
      misalign_reg   <= misalign_next;
      bus_err_reg    <= bus_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (issue) state_next = REQ;
      REQ:     if (done || abort) state_next = IDLE;
               else if (dmem_ready) state_next = RESP;
      RESP:    if (done || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall       = issue | ~idle;
    dmem_req        = (state_reg == REQ);
    wb_valid_next   = 1'b0;
    wb_rd_we_next   = 1'b0;
    wb_rd_addr_next = '0;
    wb_data_next    = '0;
    misalign_next   = 1'b0;
    bus_err_next    = 1'b0;
    if (idle && in_valid && !memop) begin
      wb_valid_next   = 1'b1;
      wb_rd_we_next   = rd_write_enable;
      wb_rd_addr_next = rd_write_addr;
      // The reserved res_src code falls back to the ALU result.
      case (res_src)
        RES_ALU: wb_data_next = exec_out;
        RES_PC:  wb_data_next = next_pc;
        default: wb_data_next = exec_out;
      endcase
    end else if (idle && memop && !aligned) begin
      wb_valid_next   = 1'b1;
      wb_rd_addr_next = rd_write_addr;
      misalign_next   = 1'b1;
    end else if (done) begin
      wb_valid_next   = 1'b1;
      wb_rd_we_next   = rd_we_reg;
      wb_rd_addr_next = rd_addr_reg;
      wb_data_next    = we_reg ? 32'h0 : dmem_rdata;
    end else if (abort) begin
      wb_valid_next   = 1'b1;
      wb_rd_addr_next = rd_addr_reg;
      bus_err_next    = 1'b1;
    end
  end

  assign dmem_we      = we_reg;
  assign dmem_addr    = addr_reg;
  assign dmem_wdata   = wdata_reg;
  assign wb_valid     = wb_valid_reg;
  assign wb_rd_we     = wb_rd_we_reg;
  assign wb_rd_addr   = wb_rd_addr_reg;
  assign wb_data      = wb_data_reg;
  assign misalign_err = misalign_reg;
  assign bus_err      = bus_err_reg;
endmodule
